// File: rtl/cache_pkg.sv
// cache_pkg: shared state type, funct3 encodings and geometry helpers for data_cache.
package cache_pkg;
   typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
   localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
   function automatic int index_w(input int sets);
      return $clog2(sets);
   endfunction
   function automatic int tag_w(input int aw, input int sets);
      return aw - $clog2(sets) - 2;
   endfunction
   function automatic logic legal_load(input logic [2:0] f);
      return f inside {LB, LH, LW, LBU, LHU};
   endfunction
   function automatic logic legal_store(input logic [2:0] f);
      return f inside {SB, SH, SW};
   endfunction
endpackage

// File: rtl/data_cache_load_align.sv
// load_align: picks the addressed byte/half of a big-endian-lane word and extends it per funct3.
module load_align
   import cache_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);
   logic [31:0] sh;
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      sh = word >> {~offset, 3'b000};
      b = sh[7:0];
      h = offset[1] ? word[15:0] : word[31:16];
      data = funct3 == LB  ? {{24{b[7]}}, b} :
             funct3 == LBU ? {24'b0, b} :
             funct3 == LH  ? {{16{h[15]}}, h} :
             funct3 == LHU ? {16'b0, h} : word;
   end
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, one-word-line, write-through/no-allocate data cache.
module data_cache
   import cache_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SETS = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0]    cpu_wdata,
   input  logic [2:0]               cpu_memcontrol,
   output logic [DATA_WIDTH-1:0]    cpu_rdata,
   output logic                     cpu_stall,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic [2:0]               mem_memcontrol,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   input  logic                     mem_ready,
   output logic [31:0]              hit_count,
   output logic [31:0]              miss_count
);
   localparam int IW = index_w(SETS);
   localparam int TW = tag_w(ADDRESS_WIDTH, SETS);
   state_t state;
   logic refilled;
   logic [SETS-1:0] valid;
   logic [TW-1:0] tags [SETS];
   logic [DATA_WIDTH-1:0] words [SETS];
   logic [IW-1:0] idx;
   logic [TW-1:0] tag;
   logic [1:0] off;
   logic [4:0] sh;
   logic hit, legal, accept;
   logic [DATA_WIDTH-1:0] line, merged, aligned;
   assign idx = cpu_addr[IW+1:2];
   assign tag = cpu_addr[ADDRESS_WIDTH-1:IW+2];
   assign off = cpu_addr[1:0];
   assign sh = {~off, 3'b000};
   assign line = words[idx];
   assign hit = valid[idx] && tags[idx] == tag;
   assign legal = cpu_we ? legal_store(cpu_memcontrol) : legal_load(cpu_memcontrol);
   assign accept = state == IDLE && cpu_req && legal;
   load_align u_align (.word(line), .offset(off), .funct3(cpu_memcontrol), .data(aligned));
   // store data is right-aligned; shift it into its big-endian lane before merging
   assign merged = cpu_memcontrol == SB ? (line & ~(32'hFF << sh)) | ({24'b0, cpu_wdata[7:0]} << sh) :
                   cpu_memcontrol == SH ? (off[1] ? {line[31:16], cpu_wdata[15:0]} : {cpu_wdata[15:0], line[15:0]}) :
                   cpu_wdata;
   assign cpu_rdata = legal ? aligned : 32'hDEADBEEF;
   assign cpu_stall = state == REFILL || (state == WRITE && !mem_ready) || (accept && (cpu_we || !hit));
   assign mem_req = state != IDLE;
   assign mem_we = state == WRITE;
   assign mem_addr = state == WRITE ? cpu_addr : {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
   assign mem_wdata = cpu_wdata;
   assign mem_memcontrol = state == WRITE ? cpu_memcontrol : LW;
   // the cycle after a refill replays the same load, so it must not be counted again
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         valid <= '0;
         refilled <= 1'b0;
         hit_count <= '0;
         miss_count <= '0;
      end else begin
         refilled <= state == REFILL && mem_ready;
         if (accept && !refilled && hit) hit_count <= hit_count + 32'd1;
         if (accept && !refilled && !hit) miss_count <= miss_count + 32'd1;
         case (state)
            IDLE: state <= accept && cpu_we ? WRITE : accept && !hit ? REFILL : IDLE;
            REFILL: if (mem_ready) begin
               valid[idx] <= 1'b1;
               tags[idx] <= tag;
               words[idx] <= mem_rdata;
               state <= IDLE;
            end
            WRITE: if (mem_ready) begin
               if (hit) words[idx] <= merged;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed vector table plus reset/illegal sequences against a latency-programmable memory.
module tb_data_cache;
   import cache_pkg::*;
   logic clk = 0, rst = 1, cpu_req = 0, cpu_we = 0;
   logic [31:0] cpu_addr = 0, cpu_wdata = 0;
   logic [2:0] cpu_memcontrol = 0;
   logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata, hit_count, miss_count;
   logic cpu_stall, mem_req, mem_we, mem_ready;
   logic [2:0] mem_memcontrol;
   int total = 0, bad = 0, lat = 1, wait_cnt = 0, wr_cnt = 0, req_cyc = 0;
   logic [31:0] last_wa = 0;
   logic [2:0] last_f3 = 0;
   logic [31:0] mem [256];
   logic [255:0] wrote = '0;

   data_cache dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_memcontrol(cpu_memcontrol), .cpu_rdata(cpu_rdata),
      .cpu_stall(cpu_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_memcontrol(mem_memcontrol), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] midx(input logic [31:0] a);
      return {a[17:16], a[7:2]};
   endfunction

   function automatic logic [31:0] init_word(input logic [31:0] a);
      case (a & 32'hFFFF_FFFC)
         32'h10000: return 32'h11223344;
         32'h10010: return 32'h91000000;
         32'h10040: return 32'h55667788;
         32'h30000: return 32'h0BADF00D;
         default:   return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] wmerge(input logic [31:0] old, d, a, input logic [2:0] f3);
      logic [31:0] r;
      r = old;
      if (f3 == SB) r[24 - 8 * a[1:0] +: 8] = d[7:0];
      else if (f3 == SH && a[1]) r[15:0] = d[15:0];
      else if (f3 == SH) r[31:16] = d[15:0];
      else r = d;
      return r;
   endfunction

   // backing memory: mem_ready in the lat-th cycle of each request
   assign mem_ready = mem_req && (wait_cnt == lat - 1);
   assign mem_rdata = wrote[midx(mem_addr)] ? mem[midx(mem_addr)] : init_word(mem_addr);

   always @(posedge clk) begin
      req_cyc <= req_cyc + (mem_req ? 1 : 0);
      wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
      if (mem_ready && mem_we) begin
         wr_cnt <= wr_cnt + 1;
         last_wa <= mem_addr;
         last_f3 <= mem_memcontrol;
         mem[midx(mem_addr)] <= wmerge(mem_rdata, mem_wdata, mem_addr, mem_memcontrol);
         wrote[midx(mem_addr)] <= 1'b1;
      end
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, output logic [31:0] rd, output int st);
      cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_memcontrol = f3;
      st = 0;
      rd = 'x;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!cpu_stall) begin
            rd = cpu_rdata;
            break;
         end
         st++;
      end
      @(posedge clk);
      #1 cpu_req = 0;
   endtask

   typedef struct {
      logic we; logic [31:0] addr, wdata; logic [2:0] f3;
      int lat, st; logic [31:0] rd; int h, m, wr, mc;
   } vec_t;
   localparam int NV = 21;
   vec_t vecs [NV];

   initial begin
      logic [31:0] rd;
      int st, rc0;
      vecs[0]  = '{0, 32'h10000, 32'h0, LW, 2, 3, 32'h11223344, 0, 1, 0, 2};
      vecs[1]  = '{0, 32'h10000, 32'h0, LW, 1, 0, 32'h11223344, 1, 1, 0, 0};
      vecs[2]  = '{0, 32'h10003, 32'h0, LB, 1, 0, 32'h00000044, 2, 1, 0, 0};
      vecs[3]  = '{0, 32'h10002, 32'h0, LHU, 1, 0, 32'h00003344, 3, 1, 0, 0};
      vecs[4]  = '{0, 32'h10000, 32'h0, LH, 1, 0, 32'h00001122, 4, 1, 0, 0};
      vecs[5]  = '{0, 32'h10001, 32'h0, LBU, 1, 0, 32'h00000022, 5, 1, 0, 0};
      vecs[6]  = '{0, 32'h10010, 32'h0, LB, 1, 2, 32'hFFFFFF91, 5, 2, 0, 1};
      vecs[7]  = '{0, 32'h10011, 32'h0, LH, 1, 0, 32'hFFFF9100, 6, 2, 0, 0};
      vecs[8]  = '{1, 32'h10001, 32'hAB, SB, 1, 1, 32'h0, 7, 2, 1, 1};
      vecs[9]  = '{0, 32'h10003, 32'h0, LW, 1, 0, 32'h11AB3344, 8, 2, 1, 0};
      vecs[10] = '{1, 32'h10002, 32'h5566, SH, 3, 3, 32'h0, 9, 2, 2, 3};
      vecs[11] = '{0, 32'h10000, 32'h0, LW, 1, 0, 32'h11AB5566, 10, 2, 2, 0};
      vecs[12] = '{1, 32'h20000, 32'hCAFEF00D, SW, 1, 1, 32'h0, 10, 3, 3, 1};
      vecs[13] = '{0, 32'h20000, 32'h0, LW, 1, 2, 32'hCAFEF00D, 10, 4, 3, 1};
      vecs[14] = '{0, 32'h20000, 32'h0, LW, 1, 0, 32'hCAFEF00D, 11, 4, 3, 0};
      vecs[15] = '{0, 32'h10040, 32'h0, LW, 1, 2, 32'h55667788, 11, 5, 3, 1};
      vecs[16] = '{0, 32'h10000, 32'h0, LW, 1, 2, 32'h11AB5566, 11, 6, 3, 1};
      vecs[17] = '{0, 32'h10000, 32'h0, 3'b011, 1, 0, 32'hDEADBEEF, 11, 6, 3, 0};
      vecs[18] = '{1, 32'h10000, 32'h0, 3'b011, 1, 0, 32'h0, 11, 6, 3, 0};
      vecs[19] = '{0, 32'h10003, 32'h0, LBU, 1, 0, 32'h00000066, 12, 6, 3, 0};
      vecs[20] = '{0, 32'h10002, 32'h0, LB, 1, 0, 32'h00000055, 13, 6, 3, 0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset mem_req", mem_req, 0);
      chk("reset stall", cpu_stall, 0);
      chk("reset hits", hit_count, 0);
      chk("reset misses", miss_count, 0);
      rst = 0;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         lat = vecs[i].lat;
         rc0 = req_cyc;
         access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, st);
         chk($sformatf("v%0d stall", i), st, vecs[i].st);
         if (!vecs[i].we) chk($sformatf("v%0d rdata", i), rd, vecs[i].rd);
         chk($sformatf("v%0d hits", i), hit_count, vecs[i].h);
         chk($sformatf("v%0d misses", i), miss_count, vecs[i].m);
         chk($sformatf("v%0d writes", i), wr_cnt, vecs[i].wr);
         chk($sformatf("v%0d memcycles", i), req_cyc - rc0, vecs[i].mc);
         if (vecs[i].we && vecs[i].mc > 0) begin
            chk($sformatf("v%0d waddr", i), last_wa, vecs[i].addr);
            chk($sformatf("v%0d wf3", i), last_f3, vecs[i].f3);
         end
      end

      // reset in the middle of a slow refill
      lat = 100;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30002; cpu_memcontrol = LW;
      @(negedge clk);
      chk("idle miss stall", cpu_stall, 1);
      chk("idle no mem_req", mem_req, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("refill mem_req", mem_req, 1);
      chk("refill mem_we", mem_we, 0);
      chk("refill mem_addr", mem_addr, 32'h30000);
      chk("refill funct3", mem_memcontrol, LW);
      @(posedge clk);
      #1 rst = 1; cpu_req = 0;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("abort mem_req", mem_req, 0);
      chk("abort stall", cpu_stall, 0);
      chk("abort hits", hit_count, 0);
      chk("abort misses", miss_count, 0);
      @(posedge clk);
      #1 lat = 1;
      access(0, 32'h30000, 0, LW, rd, st);
      chk("post-reset stall", st, 2);
      chk("post-reset rdata", rd, 32'h0BADF00D);
      chk("post-reset misses", miss_count, 1);
      chk("post-reset hits", hit_count, 0);
      access(0, 32'h10000, 0, LW, rd, st);
      chk("invalidated stall", st, 2);
      chk("invalidated rdata", rd, 32'h11AB5566);
      chk("invalidated misses", miss_count, 2);
      access(0, 32'h30000, 0, 3'b110, rd, st);
      chk("illegal stall", st, 0);
      chk("illegal rdata", rd, 32'hDEADBEEF);
      chk("illegal misses", miss_count, 2);
      chk("illegal hits", hit_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
